// File: rtl/cfa_grad_pkg.sv
// Purpose: shared widths, shifts and saturation helper for the CFA gradient engine.
// Latency: n/a (types/constants only).
// Backpressure: n/a.
// Contents: PIX_W, GRAD_W, SHIFT_S, SHIFT_F, LSUM_W line-sum width, sat8().
package cfa_grad_pkg;

  localparam int PIX_W   = 12;  // unsigned pixel width
  localparam int GRAD_W  = 8;   // unsigned gradient / weight width
  localparam int SHIFT_S = 5;   // right shift on full-patch sums
  localparam int SHIFT_F = 3;   // right shift on centre-line gradients
  localparam int LSUM_W  = 16;  // line sums and patch totals (max 61425)

  // Clamp a wide unsigned value to the 8-bit output range.
  function automatic logic [GRAD_W-1:0] sat8(input logic [LSUM_W-1:0] x);
    return (x > LSUM_W'(255)) ? GRAD_W'(255) : x[GRAD_W-1:0];
  endfunction

endpackage

// File: rtl/cfa_line_grad.sv
// Purpose: same-colour (distance 2) gradient along one 5-pixel line.
// Latency: 2 cycles (abs-diff register, then line-sum register).
// Backpressure: none; free-running, accepts a new line every cycle.
// Ports: clk, rst (async active-high), pix_m2..pix_p2 line pixels, line_sum registered result.
module cfa_line_grad
  import cfa_grad_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  pix_m2,
  input  logic [PIX_W-1:0]  pix_m1,
  input  logic [PIX_W-1:0]  pix_p0,
  input  logic [PIX_W-1:0]  pix_p1,
  input  logic [PIX_W-1:0]  pix_p2,
  output logic [LSUM_W-1:0] line_sum
);

  function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  logic [PIX_W-1:0] ad_0, ad_1, ad_2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ad_0     <= '0;
      ad_1     <= '0;
      ad_2     <= '0;
      line_sum <= '0;
    end else begin
      ad_0     <= absdiff(pix_m2, pix_p0);
      ad_1     <= absdiff(pix_m1, pix_p1);
      ad_2     <= absdiff(pix_p0, pix_p2);
      // Three 12-bit terms fit comfortably in 16 bits (max 12285).
      line_sum <= LSUM_W'(ad_0) + LSUM_W'(ad_1) + LSUM_W'(ad_2);
    end
  end

endmodule

// File: rtl/cfa_gradient_unit.sv
// Purpose: H/V gradient magnitudes (full patch and centre line) plus blend weights for demosaicing.
// Latency: patch sampled on edge N (start=1) is visible on the outputs after edge N+3.
// Backpressure: none; one patch per cycle, outputs hold the last valid result while start=0.
// Ports: clk, rst (async active-high), start, p_<r>_<c> 5x5 patch (p_p0_p0 centre),
//        grad_hs/grad_vs/grad_hf/grad_vf gradients, w_grad_hf/w_grad_vf blend weights.
module cfa_gradient_unit
  import cfa_grad_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PIX_W-1:0]  p_m2_m2, p_m2_m1, p_m2_p0, p_m2_p1, p_m2_p2,
  input  logic [PIX_W-1:0]  p_m1_m2, p_m1_m1, p_m1_p0, p_m1_p1, p_m1_p2,
  input  logic [PIX_W-1:0]  p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2,
  input  logic [PIX_W-1:0]  p_p1_m2, p_p1_m1, p_p1_p0, p_p1_p1, p_p1_p2,
  input  logic [PIX_W-1:0]  p_p2_m2, p_p2_m1, p_p2_p0, p_p2_p1, p_p2_p2,
  output logic [GRAD_W-1:0] grad_hs,
  output logic [GRAD_W-1:0] grad_vs,
  output logic [GRAD_W-1:0] grad_hf,
  output logic [GRAD_W-1:0] grad_vf,
  output logic [GRAD_W-1:0] w_grad_hf,
  output logic [GRAD_W-1:0] w_grad_vf
);

  // grid[row][col], index 0..4 maps to offset m2..p2.
  logic [PIX_W-1:0] grid [5][5];

  assign grid[0] = '{p_m2_m2, p_m2_m1, p_m2_p0, p_m2_p1, p_m2_p2};
  assign grid[1] = '{p_m1_m2, p_m1_m1, p_m1_p0, p_m1_p1, p_m1_p2};
  assign grid[2] = '{p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2};
  assign grid[3] = '{p_p1_m2, p_p1_m1, p_p1_p0, p_p1_p1, p_p1_p2};
  assign grid[4] = '{p_p2_m2, p_p2_m1, p_p2_p0, p_p2_p1, p_p2_p2};

  logic [LSUM_W-1:0] h_sum [5];
  logic [LSUM_W-1:0] v_sum [5];

  // Stages 1-2: rows give H_i, transposed columns give V_j.
  for (genvar i = 0; i < 5; i++) begin : g_lines
    cfa_line_grad u_row (
      .clk      (clk),
      .rst      (rst),
      .pix_m2   (grid[i][0]),
      .pix_m1   (grid[i][1]),
      .pix_p0   (grid[i][2]),
      .pix_p1   (grid[i][3]),
      .pix_p2   (grid[i][4]),
      .line_sum (h_sum[i])
    );
    cfa_line_grad u_col (
      .clk      (clk),
      .rst      (rst),
      .pix_m2   (grid[0][i]),
      .pix_m1   (grid[1][i]),
      .pix_p0   (grid[2][i]),
      .pix_p1   (grid[3][i]),
      .pix_p2   (grid[4][i]),
      .line_sum (v_sum[i])
    );
  end

  // Stage 3 combinational: totals, shift, saturate, weights.
  logic [LSUM_W-1:0] hs_tot, vs_tot;
  logic [GRAD_W-1:0] hs_c, vs_c, hf_c, vf_c, wh_c, wv_c;
  logic signed [8:0] d_fine, d_half;
  logic signed [9:0] w_raw;

  assign hs_tot = h_sum[0] + h_sum[1] + h_sum[2] + h_sum[3] + h_sum[4];
  assign vs_tot = v_sum[0] + v_sum[1] + v_sum[2] + v_sum[3] + v_sum[4];

  assign hs_c = sat8(hs_tot >> SHIFT_S);
  assign vs_c = sat8(vs_tot >> SHIFT_S);
  assign hf_c = sat8(h_sum[2] >> SHIFT_F);
  assign vf_c = sat8(v_sum[2] >> SHIFT_F);

  // A stronger horizontal gradient means the horizontal estimate is less
  // trustworthy, so its weight drops below 128 (and vice versa).
  assign d_fine = $signed({1'b0, vf_c}) - $signed({1'b0, hf_c});
  assign d_half = d_fine >>> 1;  // arithmetic shift = floor division by 2
  assign w_raw  = 10'sd128 + $signed({d_half[8], d_half});

  always_comb begin
    wh_c = w_raw[GRAD_W-1:0];
    if (w_raw < 10'sd0)
      wh_c = '0;
    else if (w_raw > 10'sd255)
      wh_c = '1;
  end

  assign wv_c = GRAD_W'(255) - wh_c;

  // s3_* follows the pipeline every cycle; the visible outputs only take a
  // new value when the matching valid bit arrives, so they hold otherwise.
  logic [GRAD_W-1:0] s3_hs, s3_vs, s3_hf, s3_vf, s3_wh, s3_wv;
  logic [2:0]        vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld       <= '0;
      s3_hs     <= '0;
      s3_vs     <= '0;
      s3_hf     <= '0;
      s3_vf     <= '0;
      s3_wh     <= '0;
      s3_wv     <= '0;
      grad_hs   <= '0;
      grad_vs   <= '0;
      grad_hf   <= '0;
      grad_vf   <= '0;
      w_grad_hf <= '0;
      w_grad_vf <= '0;
    end else begin
      vld   <= {vld[1:0], start};
      s3_hs <= hs_c;
      s3_vs <= vs_c;
      s3_hf <= hf_c;
      s3_vf <= vf_c;
      s3_wh <= wh_c;
      s3_wv <= wv_c;
      if (vld[2]) begin
        grad_hs   <= s3_hs;
        grad_vs   <= s3_vs;
        grad_hf   <= s3_hf;
        grad_vf   <= s3_vf;
        w_grad_hf <= s3_wh;
        w_grad_vf <= s3_wv;
      end
    end
  end

endmodule

// File: tb/tb_cfa_gradient_unit.sv
module tb_cfa_gradient_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] pix [5][5];
  logic [7:0]  grad_hs, grad_vs, grad_hf, grad_vf, w_grad_hf, w_grad_vf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cfa_gradient_unit dut (
    .clk(clk), .rst(rst), .start(start),
    .p_m2_m2(pix[0][0]), .p_m2_m1(pix[0][1]), .p_m2_p0(pix[0][2]), .p_m2_p1(pix[0][3]), .p_m2_p2(pix[0][4]),
    .p_m1_m2(pix[1][0]), .p_m1_m1(pix[1][1]), .p_m1_p0(pix[1][2]), .p_m1_p1(pix[1][3]), .p_m1_p2(pix[1][4]),
    .p_p0_m2(pix[2][0]), .p_p0_m1(pix[2][1]), .p_p0_p0(pix[2][2]), .p_p0_p1(pix[2][3]), .p_p0_p2(pix[2][4]),
    .p_p1_m2(pix[3][0]), .p_p1_m1(pix[3][1]), .p_p1_p0(pix[3][2]), .p_p1_p1(pix[3][3]), .p_p1_p2(pix[3][4]),
    .p_p2_m2(pix[4][0]), .p_p2_m1(pix[4][1]), .p_p2_p0(pix[4][2]), .p_p2_p1(pix[4][3]), .p_p2_p2(pix[4][4]),
    .grad_hs(grad_hs), .grad_vs(grad_vs), .grad_hf(grad_hf), .grad_vf(grad_vf),
    .w_grad_hf(w_grad_hf), .w_grad_vf(w_grad_vf)
  );

  typedef struct packed {
    logic [7:0] hs, vs, hf, vf, wh, wv;
  } res_t;

  typedef struct packed {
    bit   v;
    res_t r;
  } ent_t;

  // Table record: one row profile (col[c] for each column), optionally transposed.
  typedef struct packed {
    logic [4:0][11:0] col;
    bit               transpose;
    res_t             exp;
  } vec_t;

  ent_t hist[$];   // one entry per clock edge: was a patch sampled, and its result
  res_t cur_exp;   // what the outputs must show right now

  function automatic int clamp_int(input int x, input int lo, input int hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  // Reference: straight from the arithmetic definition of the gradients.
  function automatic res_t model();
    int   h [5];
    int   v [5];
    int   hs_t, vs_t, d, half, a, b;
    res_t m;
    hs_t = 0;
    vs_t = 0;
    for (int k = 0; k < 5; k++) begin
      h[k] = 0;
      v[k] = 0;
      for (int s = 0; s < 3; s++) begin
        a = int'(pix[k][s]);  b = int'(pix[k][s+2]);
        h[k] += (a > b) ? a - b : b - a;
        a = int'(pix[s][k]);  b = int'(pix[s+2][k]);
        v[k] += (a > b) ? a - b : b - a;
      end
      hs_t += h[k];
      vs_t += v[k];
    end
    m.hs = 8'(clamp_int(hs_t / 32, 0, 255));
    m.vs = 8'(clamp_int(vs_t / 32, 0, 255));
    m.hf = 8'(clamp_int(h[2] / 8, 0, 255));
    m.vf = 8'(clamp_int(v[2] / 8, 0, 255));
    d    = int'(m.vf) - int'(m.hf);
    half = (d >= 0) ? d / 2 : -((1 - d) / 2);   // floor(d/2)
    m.wh = 8'(clamp_int(128 + half, 0, 255));
    m.wv = 8'(255 - int'(m.wh));
    return m;
  endfunction

  function automatic res_t dut_res();
    return '{hs: grad_hs, vs: grad_vs, hf: grad_hf, vf: grad_vf, wh: w_grad_hf, wv: w_grad_vf};
  endfunction

  task automatic compare(input string name, input res_t want);
    res_t got;
    got = dut_res();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t: got hs=%0d vs=%0d hf=%0d vf=%0d wh=%0d wv=%0d, expected hs=%0d vs=%0d hf=%0d vf=%0d wh=%0d wv=%0d",
               name, $time, got.hs, got.vs, got.hf, got.vf, got.wh, got.wv,
               want.hs, want.vs, want.hf, want.vf, want.wh, want.wv);
    end
  endtask

  // Drive start for one edge, advance the latency model, check #1 after the edge.
  task automatic step(input bit s, input string name);
    ent_t e;
    ent_t old;
    start = s;
    e.v = s;
    e.r = model();
    @(posedge clk);
    hist.push_back(e);
    if (hist.size() > 3) begin
      old = hist.pop_front();
      if (old.v) cur_exp = old.r;
    end
    #1;
    compare(name, cur_exp);
  endtask

  task automatic load_vec(input vec_t v);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        pix[r][c] = v.transpose ? v.col[r] : v.col[c];
  endtask

  task automatic random_pix();
    int mode, base, x;
    mode = int'($urandom_range(0, 2));
    base = int'($urandom_range(0, 4095));
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        case (mode)
          0:       x = int'($urandom_range(0, 4095));
          1:       x = base + int'($urandom_range(0, 63)) - 32;
          default: x = base + int'($urandom_range(0, 599)) - 300;
        endcase
        pix[r][c] = 12'(clamp_int(x, 0, 4095));
      end
  endtask

  function automatic vec_t mk(input int c0, input int c1, input int c2, input int c3, input int c4,
                              input bit tr, input int hs, input int vs, input int hf,
                              input int vf, input int wh, input int wv);
    vec_t v;
    v.col[0] = 12'(c0); v.col[1] = 12'(c1); v.col[2] = 12'(c2);
    v.col[3] = 12'(c3); v.col[4] = 12'(c4);
    v.transpose = tr;
    v.exp = '{hs: 8'(hs), vs: 8'(vs), hf: 8'(hf), vf: 8'(vf), wh: 8'(wh), wv: 8'(wv)};
    return v;
  endfunction

  vec_t vecs [4];
  res_t zero_res;

  initial begin
    vecs[0] = mk(1000, 1000, 1000, 1000, 1000, 1'b0,   0,   0,   0,   0, 128, 127);
    vecs[1] = mk(   0,  100,  200,  300,  400, 1'b0,  93,   0,  75,   0,  90, 165);
    vecs[2] = mk(   0,    0, 4095, 4095,    0, 1'b0, 255,   0, 255,   0,   0, 255);
    vecs[3] = mk(   0,    0, 4095, 4095,    0, 1'b1,   0, 255,   0, 255, 255,   0);
    zero_res = '0;
    cur_exp  = '0;

    rst   = 1'b0;
    start = 1'b0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        pix[r][c] = '0;

    #1 rst = 1'b1;
    #1 compare("reset_state", zero_res);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed table: one patch, then three idle edges until it appears.
    foreach (vecs[i]) begin
      load_vec(vecs[i]);
      step(1'b1, "tbl_model");
      step(1'b0, "tbl_model");
      step(1'b0, "tbl_model");
      step(1'b0, "tbl_model");
      compare($sformatf("tbl_%0d", i), vecs[i].exp);
    end

    // Back-to-back flat/ramp, then idle: outputs must hold the last result.
    for (int k = 0; k < 10; k++) begin
      load_vec(vecs[k % 2]);
      step(1'b1, "stream");
    end
    for (int k = 0; k < 3; k++) step(1'b0, "stream_drain");
    compare("stream_last_ramp", vecs[1].exp);
    for (int k = 0; k < 8; k++) begin
      random_pix();
      step(1'b0, "hold");
    end
    compare("hold_after_idle", vecs[1].exp);

    // Random patches with random start gaps.
    for (int k = 0; k < 300; k++) begin
      random_pix();
      step(($urandom_range(0, 3) != 0), "random");
    end

    // Reset between edges with patches in flight.
    for (int k = 0; k < 3; k++) begin
      random_pix();
      step(1'b1, "pre_reset");
    end
    #2 rst = 1'b1;
    cur_exp = '0;
    hist.delete();
    #1 compare("async_reset", zero_res);
    @(posedge clk);
    #1 compare("reset_held", zero_res);
    #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) step(1'b0, "post_reset_idle");
    load_vec(vecs[1]);
    step(1'b1, "post_reset");
    step(1'b0, "post_reset");
    step(1'b0, "post_reset");
    compare("post_reset_latency", zero_res);
    step(1'b0, "post_reset");
    compare("post_reset_first", vecs[1].exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
